pc_gen: RTL

Parametrised program-counter generator and fetch sequencer for the core front end. It holds the architectural fetch PC and issues one instruction-fetch request at a time over a valid/ready port. It buffers the returned instruction for decode and computes branch, JAL and JALR redirect targets from execute-stage operands. It replaces the fixed 32-bit PC incrementer with a configurable width and reset vector, a stall-aware handshake, in-flight request squashing and misaligned-target detection.

---
 rtl/pc_gen.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/pc_gen.sv
// Program-counter generator and single-outstanding fetch sequencer with redirect handling.
// Define PC_GEN_RVC_EN for 2-byte alignment and compressed-instruction PC increments.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | just out of reset, heads to ST_REQ on the next clock
// ST_REQ  | fetch request presented at pc_q, waiting for accept
// ST_WAIT | request accepted, waiting for the instruction to return
// ST_HOLD | instruction buffered for decode, waiting for id_ready

module pc_gen #(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
   input  logic            clk,
   input  logic            reset,
   output logic            fetch_req_valid,
   output logic [XLEN-1:0] fetch_req_addr,
   input  logic            fetch_req_ready,
   input  logic            fetch_rsp_valid,
   input  logic [31:0]     fetch_rsp_instr,
   output logic            if_valid,
   output logic [XLEN-1:0] if_pc,
   output logic [31:0]     if_instr,
   input  logic            id_ready,
   input  logic [1:0]      redirect_kind,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic [XLEN-1:0] redirect_opa,
   input  logic [XLEN-1:0] redirect_imm,
   output logic            misalign_o
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;
   localparam logic [1:0] ST_HOLD = 2'd3;

   localparam logic [1:0] K_NONE = 2'b00;
   localparam logic [1:0] K_JALR = 2'b11;

   localparam logic [XLEN-1:0] JALR_MASK = {{(XLEN-1){1'b1}}, 1'b0};

   logic [1:0]      state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            drop_q, drop_d;
   logic            if_valid_q, if_valid_d;
   logic [XLEN-1:0] if_pc_q, if_pc_d;
   logic [31:0]     if_instr_q, if_instr_d;
   logic            misalign_q, misalign_d;

   logic [XLEN-1:0] target;
   logic [XLEN-1:0] pc_inc;
   logic            tgt_bad;
   logic            redir_req;
   logic            redir_ok;

   always_comb begin
      if (redirect_kind == K_JALR) target = (redirect_opa + redirect_imm) & JALR_MASK;
      else                         target = redirect_pc + redirect_imm;
   end

`ifdef PC_GEN_RVC_EN
   assign tgt_bad = target[0];
   assign pc_inc  = (if_instr_q[1:0] != 2'b11) ? XLEN'(2) : XLEN'(4);
`else
   assign tgt_bad = target[1];
   assign pc_inc  = XLEN'(4);
`endif

   // Redirects are only meaningful once the sequencer has left IDLE.
   assign redir_req = (state_q != ST_IDLE) && (redirect_kind != K_NONE);
   assign redir_ok  = redir_req && !tgt_bad;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      drop_d     = drop_q;
      if_valid_d = if_valid_q;
      if_pc_d    = if_pc_q;
      if_instr_d = if_instr_q;
      misalign_d = redir_req && tgt_bad;

      if (state_q == ST_IDLE) begin
         state_d = ST_REQ;
      end else if (redir_ok) begin
         pc_d       = target;
         if_valid_d = 1'b0;
         // Outstanding response still owed by memory: mark it stale and keep waiting.
         if (state_q == ST_WAIT && !fetch_rsp_valid) begin
            drop_d = 1'b1;
         end else begin
            drop_d  = 1'b0;
            state_d = ST_REQ;
         end
      end else begin
         case (state_q)
            ST_REQ: begin
               if (fetch_req_ready) state_d = ST_WAIT;
            end
            ST_WAIT: begin
               if (fetch_rsp_valid) begin
                  if (drop_q) begin
                     drop_d  = 1'b0;
                     state_d = ST_REQ;
                  end else begin
                     if_instr_d = fetch_rsp_instr;
                     if_pc_d    = pc_q;
                     if_valid_d = 1'b1;
                     state_d    = ST_HOLD;
                  end
               end
            end
            ST_HOLD: begin
               if (id_ready) begin
                  if_valid_d = 1'b0;
                  pc_d       = pc_q + pc_inc;
                  state_d    = ST_REQ;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         pc_q       <= RESET_VECTOR;
         drop_q     <= 1'b0;
         if_valid_q <= 1'b0;
         if_pc_q    <= '0;
         if_instr_q <= '0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         drop_q     <= drop_d;
         if_valid_q <= if_valid_d;
         if_pc_q    <= if_pc_d;
         if_instr_q <= if_instr_d;
         misalign_q <= misalign_d;
      end
   end

   assign fetch_req_valid = (state_q == ST_REQ);
   assign fetch_req_addr  = pc_q;
   assign if_valid        = if_valid_q;
   assign if_pc           = if_pc_q;
   assign if_instr        = if_instr_q;
   assign misalign_o      = misalign_q;

endmodule
